mc_controller: RTL and testbench

//  Multi-cycle successor to the single-cycle decoder. It latches the instruction into an internal IR and

---
 rtl/mc_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle instruction sequencer.
// Latches the fetched instruction into IR, steps FETCH/DECODE/EXEC/MEM/WB and
// issues per-state strobes around the datapath selects decoded from IR.
// Instruction and data memories use a req/ready handshake. A data access
// that waits too long is abandoned and flagged in bus_err.
module mc_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_in,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic [31:0]      ir,
    output logic             ir_we,
    output logic             pc_we,
    output logic [4:0]       npcop,
    output logic [1:0]       wrsel,
    output logic [1:0]       wdsel,
    output logic             rfwe,
    output logic [1:0]       extop,
    output logic [1:0]       asel,
    output logic [1:0]       bsel,
    output logic [4:0]       aluop,
    output logic             dmwe,
    output logic [1:0]       dmtype,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(MEM_TIMEOUT - 1);

    // opcodes
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LB   = 6'h20;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SH   = 6'h29;
    localparam logic [5:0] OP_SW   = 6'h2B;
    // R-type functs
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_SLT   = 6'h2A;

    // datapath select encodings
    localparam logic [4:0] NPC_BEQ  = 5'd1;
    localparam logic [4:0] NPC_J    = 5'd2;
    localparam logic [4:0] NPC_JR   = 5'd3;
    localparam logic [4:0] NPC_BGTZ = 5'd4;
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_OR   = 5'd2;
    localparam logic [4:0] ALU_LUI  = 5'd3;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [1:0] SEL_RT   = 2'd0;
    localparam logic [1:0] SEL_RD   = 2'd1;
    localparam logic [1:0] SEL_RA   = 2'd2;
    localparam logic [1:0] WD_DM    = 2'd1;
    localparam logic [1:0] WD_PC4   = 2'd2;
    localparam logic [1:0] EXT_SGN  = 2'd1;
    localparam logic [1:0] DM_HALF  = 2'd1;
    localparam logic [1:0] DM_BYTE  = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic [4:0] npcop;
        logic [1:0] wrsel;
        logic [1:0] wdsel;
        logic [1:0] extop;
        logic [1:0] asel;
        logic [1:0] bsel;
        logic [4:0] aluop;
        logic [1:0] dmtype;
    } dec_t;

    state_t            st;
    logic [WCNT_W-1:0] wcnt;
    dec_t              d;
    logic [5:0]        op, funct;
    logic              is_nop, is_ill, is_br, is_st, is_ld, is_mem;
    logic              wait_last;

    assign op        = ir[31:26];
    assign funct     = ir[5:0];
    assign is_nop    = (ir == 32'd0);
    assign is_mem    = is_st | is_ld;
    assign wait_last = (wcnt == WLAST);
    assign state     = st;

    assign npcop  = d.npcop;
    assign wrsel  = d.wrsel;
    assign wdsel  = d.wdsel;
    assign extop  = d.extop;
    assign asel   = d.asel;
    assign bsel   = d.bsel;
    assign aluop  = d.aluop;
    assign dmtype = d.dmtype;

    // Decode IR into datapath selects and instruction classes
    always_comb begin
        d      = '0;
        is_ill = 1'b0;
        is_br  = 1'b0;
        is_st  = 1'b0;
        is_ld  = 1'b0;
        case (op)
            OP_R: begin
                case (funct)
                    F_ADDU: begin d.wrsel = SEL_RD; d.aluop = ALU_ADD; end
                    F_SUBU: begin d.wrsel = SEL_RD; d.aluop = ALU_SUB; end
                    F_SLL:  begin d.wrsel = SEL_RD; d.asel = 2'd1; d.aluop = ALU_SLL; end
                    F_SLT:  begin d.wrsel = SEL_RD; d.aluop = ALU_SLT; end
                    F_JR:   begin d.npcop = NPC_JR; is_br = 1'b1; end
                    F_JALR: begin d.npcop = NPC_JR; d.wrsel = SEL_RD; d.wdsel = WD_PC4; end
                    default: is_ill = 1'b1;
                endcase
            end
            OP_ORI:  begin d.wrsel = SEL_RT; d.bsel = 2'd1; d.aluop = ALU_OR; end
            OP_LUI:  begin d.wrsel = SEL_RT; d.bsel = 2'd1; d.aluop = ALU_LUI; end
            OP_LW:   begin d.wdsel = WD_DM; d.extop = EXT_SGN; d.bsel = 2'd1; is_ld = 1'b1; end
            OP_LB:   begin
                d.wdsel = WD_DM; d.extop = EXT_SGN; d.bsel = 2'd1; d.dmtype = DM_BYTE; is_ld = 1'b1;
            end
            OP_SW:   begin d.extop = EXT_SGN; d.bsel = 2'd1; is_st = 1'b1; end
            OP_SH:   begin d.extop = EXT_SGN; d.bsel = 2'd1; d.dmtype = DM_HALF; is_st = 1'b1; end
            OP_BEQ:  begin d.npcop = NPC_BEQ; d.extop = EXT_SGN; d.aluop = ALU_SUB; is_br = 1'b1; end
            OP_BGTZ: begin d.npcop = NPC_BGTZ; d.extop = EXT_SGN; is_br = 1'b1; end
            OP_J:    begin d.npcop = NPC_J; is_br = 1'b1; end
            OP_JAL:  begin d.npcop = NPC_J; d.wrsel = SEL_RA; d.wdsel = WD_PC4; end
            default: is_ill = 1'b1;
        endcase
        // all-zero word would otherwise decode as sll $0,$0,0
        if (is_nop) begin
            d      = '0;
            is_ill = 1'b0;
        end
    end

    // Per-state strobes; they follow ready inputs in the same cycle, and
    // reset forces them low without waiting for a clock edge
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        rfwe     = 1'b0;
        dmwe     = 1'b0;
        if (reset) begin
            case (st)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_DECODE: pc_we = is_nop | is_ill;
                S_EXEC:   pc_we = is_br;
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmwe     = is_st;
                    // ready in the final wait cycle still counts as success
                    pc_we    = dmem_ready ? is_st : wait_last;
                end
                S_WB: begin
                    rfwe  = 1'b1;
                    pc_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sequencer: state, IR, dmem wait counter and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st      <= S_FETCH;
            ir      <= '0;
            wcnt    <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            case (st)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir <= instr_in;
                        st <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_nop || is_ill) begin
                        st <= S_FETCH;
                        if (is_ill) illegal <= 1'b1;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_br)       st <= S_FETCH;
                    else if (is_mem) st <= S_MEM;
                    else             st <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        wcnt <= '0;
                        st   <= is_ld ? S_WB : S_FETCH;
                    end else if (wait_last) begin
                        wcnt    <= '0;
                        bus_err <= 1'b1;
                        st      <= S_FETCH;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_WB:    st <= S_FETCH;
                default: st <= S_FETCH;
            endcase
        end
    end

    // Retired count advances once per PC update, wrapping naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retired <= '0;
        else        retired <= retired + CNT_W'(pc_we);
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: randomized instruction stream with random
// memory waits. Stimulus pushes expected per-instruction outcomes into a
// queue; a monitor pops one on each PC update and compares.
module tb_mc_controller;

    localparam int TMO  = 16;
    localparam int CW   = 4;
    localparam int NRND = 150;

    typedef enum int {
        M_NOP, M_ILL, M_ADDU, M_SUBU, M_SLL, M_SLT, M_JR, M_JALR, M_ORI,
        M_LUI, M_LW, M_LB, M_SW, M_SH, M_BEQ, M_BGTZ, M_J, M_JAL
    } mn_t;
    localparam int NMN = 18;

    typedef struct packed {
        int          lat;
        logic [2:0]  st_end;
        int          nreq;
        int          nrf;
        int          ndm;
        logic        rf_end;
        logic [4:0]  npcop;
        logic [1:0]  wrsel, wdsel, extop, asel, bsel;
        logic [4:0]  aluop;
        logic [1:0]  dmtype;
        logic [31:0] ir;
        logic        ill0, berr0;
        logic [CW-1:0] ret0;
    } exp_t;

    logic          clk, reset;
    logic [31:0]   instr_in;
    logic          imem_ready, dmem_ready;
    logic          imem_req, dmem_req, ir_we, pc_we, rfwe, dmwe;
    logic [31:0]   ir;
    logic [4:0]    npcop, aluop;
    logic [1:0]    wrsel, wdsel, extop, asel, bsel, dmtype;
    logic [2:0]    state;
    logic          illegal, bus_err;
    logic [CW-1:0] retired;

    mc_controller #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir(ir), .ir_we(ir_we),
        .pc_we(pc_we), .npcop(npcop), .wrsel(wrsel), .wdsel(wdsel),
        .rfwe(rfwe), .extop(extop), .asel(asel), .bsel(bsel), .aluop(aluop),
        .dmwe(dmwe), .dmtype(dmtype), .state(state), .illegal(illegal),
        .bus_err(bus_err), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    exp_t q[$];
    bit   mon_en = 0;
    int   iwait = 0, dwait = 0;
    bit   dnever = 0;
    logic          exp_ill = 0, exp_berr = 0;
    logic [CW-1:0] exp_ret = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory models: ready after the requested number of wait cycles
    int icnt = 0, dcnt = 0;
    always @(posedge clk) begin
        #1;
        if (imem_req) begin imem_ready = (icnt >= iwait); icnt++; end
        else begin imem_ready = 1'b0; icnt = 0; end
        if (dmem_req) begin dmem_ready = !dnever && (dcnt >= dwait); dcnt++; end
        else begin dmem_ready = 1'b0; dcnt = 0; end
    end

    // Monitor: tally strobes per instruction, compare at each PC update
    int   m_cyc = 0, m_req = 0, m_rf = 0, m_dm = 0;
    exp_t me;
    always @(negedge clk) begin
        if (mon_en) begin
            m_cyc++;
            if (dmem_req) m_req++;
            if (rfwe)     m_rf++;
            if (dmwe)     m_dm++;
            if (pc_we) begin
                if (q.size() == 0) begin
                    chk("unexpected_pc_we", 32'd1, 32'd0);
                end else begin
                    me = q.pop_front();
                    chk("latency", m_cyc, me.lat);
                    chk("state_at_pcwe", {29'd0, state}, {29'd0, me.st_end});
                    chk("dmem_req_cycles", m_req, me.nreq);
                    chk("rfwe_count", m_rf, me.nrf);
                    chk("dmwe_cycles", m_dm, me.ndm);
                    chk("rfwe_with_pcwe", {31'd0, rfwe}, {31'd0, me.rf_end});
                    chk("ir", ir, me.ir);
                    chk("npcop", {27'd0, npcop}, {27'd0, me.npcop});
                    chk("wrsel", {30'd0, wrsel}, {30'd0, me.wrsel});
                    chk("wdsel", {30'd0, wdsel}, {30'd0, me.wdsel});
                    chk("extop", {30'd0, extop}, {30'd0, me.extop});
                    chk("asel", {30'd0, asel}, {30'd0, me.asel});
                    chk("bsel", {30'd0, bsel}, {30'd0, me.bsel});
                    chk("aluop", {27'd0, aluop}, {27'd0, me.aluop});
                    chk("dmtype", {30'd0, dmtype}, {30'd0, me.dmtype});
                    chk("illegal", {31'd0, illegal}, {31'd0, me.ill0});
                    chk("bus_err", {31'd0, bus_err}, {31'd0, me.berr0});
                    chk("retired", {28'd0, retired}, {28'd0, me.ret0});
                end
                m_cyc = 0; m_req = 0; m_rf = 0; m_dm = 0;
            end
        end
    end

    function automatic logic [31:0] enc(input mn_t m);
        logic [4:0]  rs, rt, rd, sa;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [19:0] mid;
        rs  = 5'($urandom_range(0, 31));
        rt  = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(1, 31));
        sa  = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        tgt = 26'($urandom);
        mid = 20'($urandom);
        case (m)
            M_NOP:  enc = 32'd0;
            M_ILL:  enc = $urandom_range(0, 1) ? {6'h3F, tgt} : {6'h00, mid, 6'h3F};
            M_ADDU: enc = {6'h00, rs, rt, rd, 5'd0, 6'h21};
            M_SUBU: enc = {6'h00, rs, rt, rd, 5'd0, 6'h23};
            M_SLL:  enc = {6'h00, 5'd0, rt, rd, sa, 6'h00};
            M_SLT:  enc = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            M_JR:   enc = {6'h00, rs, 15'd0, 6'h08};
            M_JALR: enc = {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
            M_ORI:  enc = {6'h0D, rs, rt, imm};
            M_LUI:  enc = {6'h0F, 5'd0, rt, imm};
            M_LW:   enc = {6'h23, rs, rt, imm};
            M_LB:   enc = {6'h20, rs, rt, imm};
            M_SW:   enc = {6'h2B, rs, rt, imm};
            M_SH:   enc = {6'h29, rs, rt, imm};
            M_BEQ:  enc = {6'h04, rs, rt, imm};
            M_BGTZ: enc = {6'h07, rs, 5'd0, imm};
            M_J:    enc = {6'h02, tgt};
            default: enc = {6'h03, tgt};
        endcase
    endfunction

    // Reference: what each mnemonic must produce, by instruction class
    function automatic exp_t mkexp(input mn_t m, input logic [31:0] w, input int iw,
                                   input int dw, input bit tmo);
        exp_t e;
        bit ld, sd;
        e = '0;
        e.ir = w;
        ld = (m == M_LW) || (m == M_LB);
        sd = (m == M_SW) || (m == M_SH);
        case (m)
            M_ADDU: begin e.wrsel = 1; e.aluop = 0; end
            M_SUBU: begin e.wrsel = 1; e.aluop = 1; end
            M_SLL:  begin e.wrsel = 1; e.asel = 1; e.aluop = 5; end
            M_SLT:  begin e.wrsel = 1; e.aluop = 6; end
            M_JR:   e.npcop = 3;
            M_JALR: begin e.npcop = 3; e.wrsel = 1; e.wdsel = 2; end
            M_ORI:  begin e.bsel = 1; e.aluop = 2; end
            M_LUI:  begin e.bsel = 1; e.aluop = 3; end
            M_LW:   begin e.wdsel = 1; e.extop = 1; e.bsel = 1; end
            M_LB:   begin e.wdsel = 1; e.extop = 1; e.bsel = 1; e.dmtype = 2; end
            M_SW:   begin e.extop = 1; e.bsel = 1; end
            M_SH:   begin e.extop = 1; e.bsel = 1; e.dmtype = 1; end
            M_BEQ:  begin e.npcop = 1; e.extop = 1; e.aluop = 1; end
            M_BGTZ: begin e.npcop = 4; e.extop = 1; end
            M_J:    e.npcop = 2;
            M_JAL:  begin e.npcop = 2; e.wrsel = 2; e.wdsel = 2; end
            default: ;
        endcase
        if (m == M_NOP || m == M_ILL) begin
            e.lat = 2; e.st_end = 1;
        end else if (m == M_JR || m == M_BEQ || m == M_BGTZ || m == M_J) begin
            e.lat = 3; e.st_end = 2;
        end else if (ld || sd) begin
            if (tmo) begin
                e.lat = 3 + TMO; e.st_end = 3; e.nreq = TMO;
                e.ndm = sd ? TMO : 0;
            end else begin
                e.nreq = dw + 1;
                e.ndm  = sd ? dw + 1 : 0;
                if (ld) begin e.lat = 5 + dw; e.st_end = 4; e.nrf = 1; e.rf_end = 1; end
                else    begin e.lat = 4 + dw; e.st_end = 3; end
            end
        end else begin
            e.lat = 4; e.st_end = 4; e.nrf = 1; e.rf_end = 1;
        end
        e.lat += iw;
        e.ill0  = exp_ill;
        e.berr0 = exp_berr;
        e.ret0  = exp_ret;
        return e;
    endfunction

    bit abort = 0;

    task automatic run_instr(input mn_t m, input logic [31:0] w, input int iw,
                             input int dw, input bit nev);
        bit ok;
        bit mem;
        mem = (m == M_LW) || (m == M_LB) || (m == M_SW) || (m == M_SH);
        instr_in = w; iwait = iw; dwait = dw; dnever = nev;
        q.push_back(mkexp(m, w, iw, dw, mem && nev));
        exp_ret = exp_ret + 1'b1;
        if (m == M_ILL) exp_ill = 1'b1;
        if (mem && nev) exp_berr = 1'b1;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pc_we) begin ok = 1; break; end
        end
        if (!ok) begin
            failures++;
            $display("FAIL pc_we_timeout: no pc_we within 300 cycles for instr %08h", w);
            abort = 1;
        end
    endtask

    initial begin
        bit ok;
        mn_t m;
        int iw, dw;
        bit nev;
        reset = 1'b0; instr_in = 32'd0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
        chk("rst_retired", {28'd0, retired}, 32'd0);
        chk("rst_flags", {30'd0, illegal, bus_err}, 32'd0);

        // reset while a store is waiting on dmem
        instr_in = 32'hAC220004; iwait = 0; dnever = 1;
        reset = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dmem_req) begin ok = 1; break; end
        end
        chk("midmem_reached", {31'd0, ok}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("midrst_strobes", {26'd0, imem_req, dmem_req, ir_we, pc_we, rfwe, dmwe}, 32'd0);
        chk("midrst_state", {29'd0, state}, 32'd0);
        chk("midrst_ir", ir, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_retired", {28'd0, retired}, 32'd0);
        @(posedge clk);
        mon_en = 1;

        // directed cases, then a random stream
        run_instr(M_ADDU, 32'h00221821, 0, 0, 0);
        if (!abort) run_instr(M_LW, 32'h8C220004, 0, 3, 0);
        if (!abort) run_instr(M_SH, 32'hA4220002, 0, 0, 1);
        if (!abort) run_instr(M_ILL, 32'hFC000000, 0, 0, 0);
        if (!abort) run_instr(M_NOP, 32'h00000000, 0, 0, 0);
        if (!abort) run_instr(M_JAL, 32'h0C000010, 0, 0, 0);
        if (!abort) run_instr(M_LW, 32'h8C220008, 1, TMO - 1, 0);
        if (!abort) run_instr(M_SW, 32'hAC220004, 0, TMO - 1, 0);
        for (int n = 0; n < NRND && !abort; n++) begin
            m   = mn_t'($urandom_range(0, NMN - 1));
            iw  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            dw  = ($urandom_range(0, 19) == 0) ? TMO - 1
                : (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
            nev = ($urandom_range(0, 11) == 0);
            run_instr(m, enc(m), iw, dw, nev);
        end
        // stall the next fetch so nothing further retires
        iwait = 100000;
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        chk("final_illegal", {31'd0, illegal}, {31'd0, exp_ill});
        chk("final_bus_err", {31'd0, bus_err}, {31'd0, exp_berr});
        chk("final_retired", {28'd0, retired}, {28'd0, exp_ret});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
